// File: rtl/nrzi_rx_deserializer.sv
// Purpose: USB NRZI decode, bit-unstuffing with stuff-error detect, LSB-first deserialise to DATA_WIDTH words.
// Latency: d_orig/rx_data/byte_ready/stuff_err/sync_found are registered, 1 clk after the sampling edge.
// Backpressure: none; samples arrive on shift_enable strobes, and every output pulse lasts one cycle.
// Optional build macro NRZI_RX_SYNC_DETECT_EN adds a HUNT/RECV framer that waits for the SYNC pattern.
module nrzi_rx_deserializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int STUFF_LIMIT = 6
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  d_plus,
    input  logic                  shift_enable,
    input  logic                  eop,
    output logic                  d_orig,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  byte_ready,
    output logic                  stuff_err,
    output logic                  sync_found
);

    localparam int              CW       = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [3:0]      LIMIT    = 4'(STUFF_LIMIT);

    logic                  last_d_plus;
    logic [3:0]            ones_cnt;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] sr;
    logic [DATA_WIDTH-1:0] sr_next;
    logic                  sample;
    logic                  b;
    logic                  recv;
    logic                  data_sample;
    logic                  at_limit;
    logic                  sync_hit;

    // A sample point only counts when the line is not in end-of-packet.
    assign sample  = shift_enable & ~eop;
    // NRZI: no transition means a 1, a transition means a 0.
    assign b       = (d_plus == last_d_plus);
    assign at_limit = (ones_cnt == LIMIT);
    // New bit enters at the MSB so the first bit of a word ends up at bit 0.
    assign sr_next = {b, sr[DATA_WIDTH-1:1]};
    assign data_sample = sample & recv;

`ifdef NRZI_RX_SYNC_DETECT_EN
    typedef enum logic {HUNT, RECV} state_t;

    state_t     state;
    logic [7:0] window;
    logic [7:0] window_next;

    // Raw decoded bits (no unstuffing) slide through the window, newest at the MSB.
    assign window_next = {b, window[7:1]};
    // Seven 0s then a 1, received LSB-first, reads back as 8'h80.
    assign sync_hit    = sample & (state == HUNT) & (window_next == 8'h80);
    assign recv        = (state == RECV);

    // Framer: hunt for SYNC, then hand samples to the deserialiser until eop.
    // The window restarts as all-ones so fewer than eight bits can never match.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= HUNT;
            window     <= 8'hFF;
            sync_found <= 1'b0;
        end else begin
            sync_found <= sync_hit;
            if (eop) begin
                state  <= HUNT;
                window <= 8'hFF;
            end else if (sync_hit) begin
                state  <= RECV;
                window <= 8'hFF;
            end else if (sample && state == HUNT) begin
                window <= window_next;
            end
        end
    end
`else
    // Without the framer every sample after reset/eop is payload.
    assign recv       = 1'b1;
    assign sync_hit   = 1'b0;
    assign sync_found = 1'b0;
`endif

    // NRZI decode state: remembers the previous line level and the last decoded bit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            last_d_plus <= 1'b1;
            d_orig      <= 1'b1;
        end else if (eop) begin
            last_d_plus <= 1'b1;
            d_orig      <= 1'b1;
        end else if (sample) begin
            last_d_plus <= d_plus;
            d_orig      <= b;
        end
    end

    // Unstuffing and word assembly; rx_data holds across eop, pulses last one cycle.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ones_cnt   <= 4'd0;
            bit_cnt    <= '0;
            sr         <= '0;
            rx_data    <= '0;
            byte_ready <= 1'b0;
            stuff_err  <= 1'b0;
        end else begin
            byte_ready <= 1'b0;
            stuff_err  <= 1'b0;
            if (eop || sync_hit) begin
                // Packet boundary or fresh framing: drop any partial word.
                ones_cnt <= 4'd0;
                bit_cnt  <= '0;
                sr       <= '0;
            end else if (data_sample) begin
                if (at_limit) begin
                    // After a full run of 1s the next bit must be a stuffed 0.
                    ones_cnt <= 4'd0;
                    if (b) begin
                        stuff_err <= 1'b1;
                        bit_cnt   <= '0;
                        sr        <= '0;
                    end
                end else begin
                    ones_cnt <= b ? (ones_cnt + 4'd1) : 4'd0;
                    sr       <= sr_next;
                    if (bit_cnt == LAST_BIT) begin
                        rx_data    <= sr_next;
                        byte_ready <= 1'b1;
                        bit_cnt    <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_nrzi_rx_deserializer.sv
// Bench for nrzi_rx_deserializer: an 8-bit and a 4-bit instance share one stimulus stream.
// A bit-level model (line levels -> decoded bits -> unstuffed bit list -> words) predicts all outputs.
// Directed packets are built from decoded-bit vectors and NRZI-encoded by the bench.
module tb_nrzi_rx_deserializer;

    localparam int STUFF = 6;
`ifdef NRZI_RX_SYNC_DETECT_EN
    localparam bit SYNC_MODE = 1'b1;
`else
    localparam bit SYNC_MODE = 1'b0;
`endif

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic d_plus = 1'b1;
    logic shift_enable = 1'b0;
    logic eop = 1'b0;

    logic       d_orig8, br8, se8, sf8;
    logic [7:0] rx8;
    logic       d_orig4, br4, se4, sf4;
    logic [3:0] rx4;

    always #5 clk = ~clk;

    nrzi_rx_deserializer #(.DATA_WIDTH(8), .STUFF_LIMIT(STUFF)) dut8 (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .shift_enable(shift_enable), .eop(eop),
        .d_orig(d_orig8), .rx_data(rx8), .byte_ready(br8), .stuff_err(se8), .sync_found(sf8)
    );

    nrzi_rx_deserializer #(.DATA_WIDTH(4), .STUFF_LIMIT(STUFF)) dut4 (
        .clk(clk), .n_rst(n_rst), .d_plus(d_plus), .shift_enable(shift_enable), .eop(eop),
        .d_orig(d_orig4), .rx_data(rx4), .byte_ready(br4), .stuff_err(se4), .sync_found(sf4)
    );

    int tests = 0;
    int fails = 0;

    // DUT pulse counters, sampled by the compare step
    int br_cnt8 = 0;
    int br_cnt4 = 0;
    int se_cnt  = 0;
    int sf_cnt  = 0;

    // ---------------- model ----------------
    int W [2] = '{8, 4};
    bit m_last;
    bit m_dorig;
    int m_ones;
    bit m_hunt;
    bit hist [$];
    int m_n    [2];
    int m_word [2];
    int m_rx   [2];
    bit exp_br [2];
    bit exp_se;
    bit exp_sf;

    bit line = 1'b1;

    task automatic chk(input string nm, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1'b1; m_dorig = 1'b1; m_ones = 0; m_hunt = SYNC_MODE;
        hist.delete();
        m_n = '{0, 0}; m_word = '{0, 0}; m_rx = '{0, 0};
        exp_br = '{1'b0, 1'b0}; exp_se = 1'b0; exp_sf = 1'b0;
    endtask

    // Predicts the outputs visible after the next rising edge for these inputs.
    task automatic model_step(input bit se, input bit dp, input bit e);
        bit b;
        bit match;
        exp_br = '{1'b0, 1'b0}; exp_se = 1'b0; exp_sf = 1'b0;
        if (e) begin
            m_last = 1'b1; m_dorig = 1'b1; m_ones = 0; m_hunt = SYNC_MODE;
            hist.delete();
            m_n = '{0, 0}; m_word = '{0, 0};
        end else if (se) begin
            b = (dp == m_last);
            m_last = dp;
            m_dorig = b;
            if (m_hunt) begin
                hist.push_back(b);
                if (hist.size() > 8) void'(hist.pop_front());
                match = (hist.size() == 8);
                for (int i = 0; i < hist.size(); i++)
                    if (hist[i] != (i == 7)) match = 1'b0;
                if (match) begin
                    exp_sf = 1'b1; m_hunt = 1'b0; m_ones = 0;
                    m_n = '{0, 0}; m_word = '{0, 0};
                end
            end else if (m_ones == STUFF) begin
                if (b) begin
                    exp_se = 1'b1;
                    m_n = '{0, 0}; m_word = '{0, 0};
                end
                m_ones = 0;
            end else begin
                m_ones = b ? m_ones + 1 : 0;
                for (int k = 0; k < 2; k++) begin
                    m_word[k] = m_word[k] + (int'(b) << m_n[k]);
                    m_n[k]++;
                    if (m_n[k] == W[k]) begin
                        m_rx[k] = m_word[k]; exp_br[k] = 1'b1;
                        m_n[k] = 0; m_word[k] = 0;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        chk("d_orig8", int'(d_orig8), int'(m_dorig));
        chk("rx_data8", int'(rx8), m_rx[0]);
        chk("byte_ready8", int'(br8), int'(exp_br[0]));
        chk("stuff_err8", int'(se8), int'(exp_se));
        chk("sync_found8", int'(sf8), int'(exp_sf));
        chk("d_orig4", int'(d_orig4), int'(m_dorig));
        chk("rx_data4", int'(rx4), m_rx[1]);
        chk("byte_ready4", int'(br4), int'(exp_br[1]));
        chk("stuff_err4", int'(se4), int'(exp_se));
        chk("sync_found4", int'(sf4), int'(exp_sf));
        br_cnt8 += int'(br8);
        br_cnt4 += int'(br4);
        se_cnt  += int'(se8);
        sf_cnt  += int'(sf8);
    endtask

    // One cycle: check outputs at the falling edge, then apply the next inputs.
    task automatic cyc(input bit se, input bit dp, input bit e);
        @(negedge clk);
        compare();
        shift_enable = se; d_plus = dp; eop = e;
        model_step(se, dp, e);
    endtask

    task automatic send_bit(input bit b);
        if (!b) line = ~line;
        cyc(1'b1, line, 1'b0);
        cyc(1'b0, line, 1'b0);
    endtask

    task automatic send_bits(input bit v [], input int n);
        for (int i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic send_eop();
        cyc(1'b0, line, 1'b1);
        line = 1'b1;
        cyc(1'b0, line, 1'b0);
    endtask

    bit v [];
    int b8, b4, s0, f0;

    initial begin
        model_reset();
        cyc(1'b0, 1'b1, 1'b0);
        chk("reset_rx8", int'(rx8), 0);
        chk("reset_d_orig", int'(d_orig8), 1);
        chk("reset_byte_ready", int'(br8), 0);
        n_rst = 1'b1;

        // 1: eight decoded 0s right after reset
        b8 = br_cnt8; s0 = se_cnt;
        v = '{0, 0, 0, 0, 0, 0, 0, 0};
        send_bits(v, 8);
`ifndef NRZI_RX_SYNC_DETECT_EN
        chk("t1_byte_count", br_cnt8 - b8, 1);
        chk("t1_rx", int'(rx8), 8'h00);
        chk("t1_stuff_count", se_cnt - s0, 0);
`endif

        // 2: line held high -> six 1s, then a stuff violation
        send_eop();
        b8 = br_cnt8; s0 = se_cnt;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1, 1'b0);
            cyc(1'b0, 1'b1, 1'b0);
        end
        line = 1'b1;
`ifndef NRZI_RX_SYNC_DETECT_EN
        chk("t2_stuff_count", se_cnt - s0, 1);
        chk("t2_byte_count", br_cnt8 - b8, 0);
        chk("t2_model_bits_after", m_n[0], 1);
`endif

        // 3: stuffed 0 after six 1s is dropped -> 0x7F
        send_eop();
        b8 = br_cnt8; s0 = se_cnt;
        v = '{1, 1, 1, 1, 1, 1, 0, 1, 0};
        send_bits(v, 9);
`ifndef NRZI_RX_SYNC_DETECT_EN
        chk("t3_rx", int'(rx8), 8'h7F);
        chk("t3_model_rx", m_rx[0], 8'h7F);
        chk("t3_byte_count", br_cnt8 - b8, 1);
        chk("t3_stuff_count", se_cnt - s0, 0);
`endif

        // 4: five bits, eop (with a coincident ignored sample), then 0xA5
        send_eop();
        v = '{1, 0, 1, 0, 1};
        send_bits(v, 5);
        b8 = br_cnt8;
        cyc(1'b1, ~line, 1'b1);
        line = 1'b1;
        cyc(1'b0, line, 1'b0);
        v = '{1, 0, 1, 0, 0, 1, 0, 1};
        send_bits(v, 8);
`ifndef NRZI_RX_SYNC_DETECT_EN
        chk("t4_byte_count", br_cnt8 - b8, 1);
        chk("t4_rx", int'(rx8), 8'hA5);
`endif

        // 5: 1,0,1,1,0,0,1,0 -> nibbles D then 4, byte 0x4D
        send_eop();
        b4 = br_cnt4;
        v = '{1, 0, 1, 1};
        send_bits(v, 4);
`ifndef NRZI_RX_SYNC_DETECT_EN
        chk("t5_rx4_first", int'(rx4), 4'hD);
`endif
        v = '{0, 0, 1, 0};
        send_bits(v, 4);
`ifndef NRZI_RX_SYNC_DETECT_EN
        chk("t5_rx4_second", int'(rx4), 4'h4);
        chk("t5_nibble_count", br_cnt4 - b4, 2);
        chk("t5_rx8", int'(rx8), 8'h4D);
        chk("t5_model_rx8", m_rx[0], 8'h4D);
`endif

        // 6: asynchronous reset in the middle of a word
        send_eop();
        v = '{1, 1, 0};
        send_bits(v, 3);
        cyc(1'b0, line, 1'b0);
        #2 n_rst = 1'b0;
        model_reset();
        line = 1'b1;
        #1 compare();
        chk("arst_rx8", int'(rx8), 0);
        chk("arst_d_orig", int'(d_orig8), 1);
        cyc(1'b0, line, 1'b0);
        n_rst = 1'b1;
        cyc(1'b0, line, 1'b0);

`ifdef NRZI_RX_SYNC_DETECT_EN
        // 7: garbage, SYNC, then 0x3C
        send_eop();
        b8 = br_cnt8; f0 = sf_cnt;
        v = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        send_bits(v, 11);
        chk("t7_byte_before_sync", br_cnt8 - b8, 0);
        chk("t7_sync_count", sf_cnt - f0, 1);
        v = '{0, 0, 1, 1, 1, 1, 0, 0};
        send_bits(v, 8);
        chk("t7_byte_count", br_cnt8 - b8, 1);
        chk("t7_rx", int'(rx8), 8'h3C);
        chk("t7_model_rx", m_rx[0], 8'h3C);
`endif

        for (int i = 0; i < 4; i++) cyc(1'b0, line, 1'b0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule
